fft_bitrev_ctrl: RTL and testbench

Reorder controller in front of the FFT butterfly pipeline: it accepts one frame of N = 2^LOG2N samples in natural order, stores them in an internal buffer and replays them in bit-reversed index order. The index permutation uses the existing `bit_flip` datapath. This block owns the load/drain sequencing, the buffer addressing and the valid/ready handshakes on both sides.

---
 rtl/fft_pkg.sv | 14 +
 rtl/bit_flip.sv | 20 ++
 rtl/fft_bitrev_ctrl.sv | 153 +++++++++++++++
 tb/tb_fft_bitrev_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions.
// Holds the default frame geometry used by the butterfly stages and the
// reorder controller, plus the reorder controller state encoding.
package fft_pkg;

    localparam int FFT_LOG2N_DEF  = 4;
    localparam int FFT_DATA_W_DEF = 16;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } bitrev_state_e;

endpackage

// File: rtl/bit_flip.sv
// Bit-reversal of an index: idx_o[i] = idx_i[REG_LENGTH-1-i].
// Purely combinational.
// Ports:
//   idx_i  in  REG_LENGTH  natural-order index
//   idx_o  out REG_LENGTH  bit-reversed index
module bit_flip #(
    parameter int REG_LENGTH = 4
) (
    input  logic [REG_LENGTH-1:0] idx_i,
    output logic [REG_LENGTH-1:0] idx_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < REG_LENGTH; i++) begin
            idx_o[i] = idx_i[REG_LENGTH-1-i];
        end
    end

endmodule

// File: rtl/fft_bitrev_ctrl.sv
// Bit-reversal reorder controller in front of the FFT butterflies.
// Loads one frame of N = 2^LOG2N samples in natural order into a register
// buffer, then replays it in bit-reversed index order through a registered
// valid/ready output stage.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_LOAD  | accepting samples, in_ready = 1, wr_cnt addresses the buffer
//   ST_DRAIN | replaying buffer, rd_cnt walks 0..N-1 through bit_flip
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous abort of the current frame
//   in_data    in   input sample, natural order
//   in_valid   in   in_data valid
//   in_ready   out  sample accepted this cycle (state only)
//   out_data   out  output sample, bit-reversed order
//   out_valid  out  out_data valid (registered)
//   out_ready  in   downstream accepts out_data
//   out_last   out  final beat of the frame (original index N-1)
//   busy       out  high while draining
import fft_pkg::*;

module fft_bitrev_ctrl #(
    parameter int LOG2N  = FFT_LOG2N_DEF,
    parameter int DATA_W = FFT_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N:0] CNT_N    = (LOG2N+1)'(N);
    localparam logic [LOG2N:0] CNT_LAST = (LOG2N+1)'(N - 1);

    bitrev_state_e     state_q, state_d;
    logic [LOG2N:0]    wr_cnt_q, wr_cnt_d;
    logic [LOG2N:0]    rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] mem_q [N];

    logic [LOG2N-1:0]  rd_idx_flip;
    logic              in_xfer;
    logic              out_xfer;
    logic              load_out;

    bit_flip #(
        .REG_LENGTH (LOG2N)
    ) u_bit_flip (
        .idx_i (rd_cnt_q[LOG2N-1:0]),
        .idx_o (rd_idx_flip)
    );

    assign in_xfer  = in_valid && (state_q == ST_LOAD);
    assign out_xfer = out_valid_q && out_ready;
    // rd_cnt stops at N, so no reload happens once the last beat is staged.
    assign load_out = (state_q == ST_DRAIN) && (rd_cnt_q < CNT_N)
                      && (!out_valid_q || out_ready);

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (flush) begin
            // Abort wins over any concurrent transfer; buffer contents are kept.
            state_d     = ST_LOAD;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_xfer) begin
                        if (wr_cnt_q == CNT_LAST) begin
                            wr_cnt_d = '0;
                            state_d  = ST_DRAIN;
                        end else begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_xfer && out_last_q) begin
                        state_d     = ST_LOAD;
                        rd_cnt_d    = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else if (load_out) begin
                        out_data_d  = mem_q[rd_idx_flip];
                        out_valid_d = 1'b1;
                        out_last_d  = (rd_cnt_q == CNT_LAST);
                        rd_cnt_d    = rd_cnt_q + 1'b1;
                    end else if (out_xfer) begin
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Frame buffer has no reset: a frame is always fully rewritten before it
    // is drained.
    always_ff @(posedge clk) begin
        if (in_xfer && !flush) begin
            mem_q[wr_cnt_q[LOG2N-1:0]] <= in_data;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q == ST_DRAIN);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_fft_bitrev_ctrl.sv
module tb_fft_bitrev_ctrl;

    logic clk;
    logic rst_n;

    // N = 16 instance
    logic        a_flush;
    logic [15:0] a_in_data;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [15:0] a_out_data;
    logic        a_out_valid;
    logic        a_out_ready;
    logic        a_out_last;
    logic        a_busy;

    // N = 4 instance
    logic        b_flush;
    logic [7:0]  b_in_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_out_last;
    logic        b_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_g = 0;

    fft_bitrev_ctrl #(.LOG2N(4), .DATA_W(16)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (a_flush),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_last  (a_out_last),
        .busy      (a_busy)
    );

    fft_bitrev_ctrl #(.LOG2N(2), .DATA_W(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (b_flush),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_last  (b_out_last),
        .busy      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_g <= cyc_g + 1;

    // Hand-written bit-reversed order for N = 16.
    int order16 [16];
    initial begin
        order16 = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    end

    // All tasks enter and leave 1 time unit after a rising edge.
    task automatic send16(input int base, input int gap, input int n);
        int sent;
        int budget;
        logic acc;
        sent = 0;
        budget = 0;
        while (sent < n && budget < 400) begin
            for (int g = 0; g < gap; g++) begin
                a_in_valid = 1'b0;
                @(posedge clk); #1;
            end
            a_in_valid = 1'b1;
            a_in_data  = 16'(base + sent);
            @(negedge clk);
            acc = a_in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            budget++;
        end
        a_in_valid = 1'b0;
        n_cmp++;
        if (sent != n) begin
            n_err++;
            $display("FAIL send_timeout: accepted %0d samples, required %0d", sent, n);
        end
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1.
    task automatic collect16(input int base, input int mode, input int nbeats);
        int got;
        int cyc;
        int first;
        int ph;
        logic held_v;
        logic [15:0] held_d;
        logic held_l;
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        got = 0; cyc = 0; first = -1; ph = 0; held_v = 1'b0;
        held_d = '0; held_l = 1'b0;
        while (got < nbeats && cyc < 300) begin
            a_out_ready = (mode == 0) ? 1'b1 : pat[ph % 4];
            ph++;
            @(negedge clk);
            if (held_v) begin
                n_cmp++;
                if (a_out_valid !== 1'b1 || a_out_data !== held_d || a_out_last !== held_l) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                             a_out_valid, a_out_data, a_out_last, held_d, held_l);
                end
            end
            if (a_out_valid) begin
                if (first < 0) first = cyc;
                if (a_out_ready) begin
                    n_cmp++;
                    if (a_out_data !== 16'(base + order16[got]) || a_out_last !== (got == 15)) begin
                        n_err++;
                        $display("FAIL beat%0d: got d=%h l=%b, required d=%h l=%b", got,
                                 a_out_data, a_out_last, 16'(base + order16[got]), (got == 15));
                    end
                    got++;
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held_d = a_out_data;
                    held_l = a_out_last;
                end
            end else begin
                held_v = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        a_out_ready = 1'b0;
        n_cmp++;
        if (got != nbeats) begin
            n_err++;
            $display("FAIL collect_timeout: got %0d beats, required %0d", got, nbeats);
        end
        if (mode == 0 && nbeats == 16) begin
            n_cmp++;
            if (first != 1) begin
                n_err++;
                $display("FAIL first_out_latency: got %0d cycles, required 1", first);
            end
            n_cmp++;
            if (a_in_ready !== 1'b1 || (cyc - first) != 16) begin
                n_err++;
                $display("FAIL in_ready_return: got in_ready=%b after %0d cycles, required 1 after 16",
                         a_in_ready, cyc - first);
            end
        end
        if (nbeats == 16) begin
            @(negedge clk);
            n_cmp++;
            if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL frame_end: got v=%b busy=%b in_ready=%b, required 0 0 1",
                         a_out_valid, a_busy, a_in_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_drain_start(input string tag);
        n_cmp++;
        if (a_busy !== 1'b1 || a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_drain_start: got busy=%b in_ready=%b v=%b, required 1 0 0",
                     tag, a_busy, a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_flush = 1'b0; a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        #3;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_out_data !== 16'h0 || a_out_last !== 1'b0 || a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a: got v=%b d=%h l=%b busy=%b, required 0 0000 0 0",
                     a_out_valid, a_out_data, a_out_last, a_busy);
        end
        n_cmp++;
        if (b_out_valid !== 1'b0 || b_out_data !== 8'h0 || b_out_last !== 1'b0 || b_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b: got v=%b d=%h l=%b busy=%b, required 0 00 0 0",
                     b_out_valid, b_out_data, b_out_last, b_busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got a=%b b=%b, required 1 1", a_in_ready, b_in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_natural_frame();
        send16(0, 0, 16);
        check_drain_start("natural");
        collect16(0, 0, 16);
    endtask

    task automatic test_stall();
        send16(0, 0, 16);
        check_drain_start("stall");
        collect16(0, 1, 16);
    endtask

    task automatic test_in_gaps();
        send16(16'h20, 2, 16);
        check_drain_start("gaps");
        collect16(16'h20, 0, 16);
    endtask

    task automatic test_flush();
        send16(50, 0, 7);
        a_in_valid = 1'b1;
        a_in_data  = 16'd57;
        a_flush    = 1'b1;
        @(posedge clk); #1;
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        n_cmp++;
        if (a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_state: got in_ready=%b busy=%b v=%b, required 1 0 0",
                     a_in_ready, a_busy, a_out_valid);
        end
        send16(100, 0, 16);
        check_drain_start("flush");
        collect16(100, 0, 16);
    endtask

    task automatic test_reset_mid_drain();
        send16(16'h40, 0, 16);
        collect16(16'h40, 0, 5);
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_beat5: got v=%b busy=%b, required 1 1", a_out_valid, a_busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_out_last !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b busy=%b l=%b, required 0 0 0",
                     a_out_valid, a_busy, a_out_last);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_in_ready: got %b, required 1", a_in_ready);
        end
        @(posedge clk); #1;
        send16(16'h300, 0, 16);
        check_drain_start("after_reset");
        collect16(16'h300, 0, 16);
    endtask

    task automatic test_back_to_back();
        logic [7:0] src [8];
        logic [7:0] expv [8];
        int acc_cyc [8];
        src  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
        expv = '{8'hA0, 8'hA2, 8'hA1, 8'hA3, 8'hB0, 8'hB2, 8'hB1, 8'hB3};
        for (int k = 0; k < 8; k++) acc_cyc[k] = 0;
        b_out_ready = 1'b1;
        fork
            begin : drv
                int i;
                int budget;
                i = 0; budget = 0;
                while (i < 8 && budget < 100) begin
                    b_in_valid = 1'b1;
                    b_in_data  = src[i];
                    @(negedge clk);
                    if (b_in_ready) begin
                        acc_cyc[i] = cyc_g;
                        i++;
                    end
                    @(posedge clk); #1;
                    budget++;
                end
                b_in_valid = 1'b0;
                n_cmp++;
                if (i != 8) begin
                    n_err++;
                    $display("FAIL b2b_send_timeout: accepted %0d, required 8", i);
                end
            end
            begin : mon
                int j;
                int budget;
                j = 0; budget = 0;
                while (j < 8 && budget < 100) begin
                    @(negedge clk);
                    if (b_out_valid) begin
                        n_cmp++;
                        if (b_out_data !== expv[j] || b_out_last !== (j == 3 || j == 7)) begin
                            n_err++;
                            $display("FAIL b2b_beat%0d: got d=%h l=%b, required d=%h l=%b", j,
                                     b_out_data, b_out_last, expv[j], (j == 3 || j == 7));
                        end
                        j++;
                    end
                    @(posedge clk); #1;
                    budget++;
                end
                n_cmp++;
                if (j != 8) begin
                    n_err++;
                    $display("FAIL b2b_collect_timeout: got %0d beats, required 8", j);
                end
            end
        join
        b_out_ready = 1'b0;
        n_cmp++;
        if ((acc_cyc[4] - acc_cyc[0]) != 9) begin
            n_err++;
            $display("FAIL b2b_frame_period: got %0d cycles, required 9", acc_cyc[4] - acc_cyc[0]);
        end
    endtask

    initial begin
        test_reset();
        test_natural_frame();
        test_stall();
        test_in_gaps();
        test_flush();
        test_reset_mid_drain();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
